// File: rtl/uart_reg_pkg.sv
// Shared types for the UART register-file port arbiter.
//   - FSM state encoding for uart_reg_arbiter
//   - requester command encodings (CMD_RD/CMD_WR/CMD_FAIL/CMD_ILL)
//   - default widths and the command -> register strobe decode
package uart_reg_pkg;

   localparam int unsigned DEF_NUM_REQ     = 2;
   localparam int unsigned DEF_ADDR_W      = 8;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_TIMEOUT_CYC = 16;
   localparam int unsigned CMD_W           = 2;

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      CMD_RD   = 2'b00,
      CMD_WR   = 2'b01,
      CMD_FAIL = 2'b10,
      CMD_ILL  = 2'b11
   } req_cmd_t;

   // Register-block command strobes, exactly one set per issued command
   typedef struct packed {
      logic state_r;
      logic state_w;
      logic state_fail;
   } reg_strobe_t;

   // Illegal commands are reported to the register block as a fail-report
   function automatic reg_strobe_t cmd_to_strobe(input logic [CMD_W-1:0] cmd);
      reg_strobe_t s;
      s = '0;
      case (cmd)
         CMD_RD:  s.state_r    = 1'b1;
         CMD_WR:  s.state_w    = 1'b1;
         default: s.state_fail = 1'b1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   valid    in   NUM_REQ   pending requests
//   ptr      in   IDX_W     highest-priority index this round
//   grant_c  out  NUM_REQ   one-hot winner (0 when nothing valid)
//   idx_c    out  IDX_W     binary index of the winner
//   any_c    out  1         at least one request valid
module uart_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [IDX_W-1:0]   idx_c,
   output logic               any_c
);

   int unsigned cand;

   // Scan from ptr upward, wrapping; first valid candidate wins
   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!any_c && valid[cand[IDX_W-1:0]]) begin
            any_c                      = 1'b1;
            idx_c                      = cand[IDX_W-1:0];
            grant_c[cand[IDX_W-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_reg_arbiter.sv
// Shares the single UART register-file port among NUM_REQ requesters.
// Round-robin grant, one START/DONE transaction at a time, response routed
// back to the winner. Optional WAIT timeout under `UART_ARB_TIMEOUT_EN.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   REQ_VALID/CMD/ADDR/DATA        per-requester request (packed, index 0 in LSBs)
//   REQ_READY                      one-cycle one-hot grant pulse
//   RSP_VALID/DATA/OK/ERR          one-cycle one-hot response to the winner
//   BUSY                           transaction in flight
//   REG_START, REG_STATE_R/W/FAIL  register-block strobes
//   REG_ADDR, REG_DATA_IN          register-block address/data (valid with START)
//   REG_DATA_OUT, REG_STATE_R_OUT, REG_OK, REG_FAIL_OUT, REG_DONE  register results
module uart_reg_arbiter
   import uart_reg_pkg::*;
#(
   parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        REQ_VALID,
   input  logic [CMD_W*NUM_REQ-1:0]  REQ_CMD,
   input  logic [ADDR_W*NUM_REQ-1:0] REQ_ADDR,
   input  logic [DATA_W*NUM_REQ-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]        REQ_READY,
   output logic [NUM_REQ-1:0]        RSP_VALID,
   output logic [DATA_W-1:0]         RSP_DATA,
   output logic                      RSP_OK,
   output logic                      RSP_ERR,
   output logic                      BUSY,
   output logic                      REG_START,
   output logic                      REG_STATE_R,
   output logic                      REG_STATE_W,
   output logic                      REG_STATE_FAIL,
   output logic [ADDR_W-1:0]         REG_ADDR,
   output logic [DATA_W-1:0]         REG_DATA_IN,
   input  logic [DATA_W-1:0]         REG_DATA_OUT,
   input  logic                      REG_STATE_R_OUT,
   input  logic                      REG_OK,
   input  logic                      REG_FAIL_OUT,
   input  logic                      REG_DONE
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t          state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [NUM_REQ-1:0]  owner;
   logic [CMD_W-1:0]    cmd_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;

   logic [NUM_REQ-1:0]  grant_c;
   logic [IDX_W-1:0]    idx_c;
   logic                any_c;
   logic [IDX_W-1:0]    ptr_next_c;
   logic [CMD_W-1:0]    sel_cmd_c;
   logic [ADDR_W-1:0]   sel_addr_c;
   logic [DATA_W-1:0]   sel_data_c;
   reg_strobe_t         strb_c;
   logic                rsp_err_c;
   logic                rsp_ok_c;
   logic [DATA_W-1:0]   rsp_data_c;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] to_cnt;
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .valid   (REQ_VALID),
      .ptr     (rr_ptr),
      .grant_c (grant_c),
      .idx_c   (idx_c),
      .any_c   (any_c)
   );

   // Pointer moves just past the winner
   assign ptr_next_c = (idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : idx_c + IDX_W'(1);

   // Select the winner's request fields
   always_comb begin
      sel_cmd_c  = '0;
      sel_addr_c = '0;
      sel_data_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_c[i]) begin
            sel_cmd_c  = REQ_CMD[i*CMD_W +: CMD_W];
            sel_addr_c = REQ_ADDR[i*ADDR_W +: ADDR_W];
            sel_data_c = REQ_DATA[i*DATA_W +: DATA_W];
         end
      end
   end

   assign strb_c = cmd_to_strobe(cmd_q);

   // Illegal commands only reach the register block as FAIL, so flag them here
   always_comb begin
      rsp_err_c  = REG_FAIL_OUT | (cmd_q == CMD_ILL);
      rsp_ok_c   = REG_OK & ~rsp_err_c;
      rsp_data_c = (REG_STATE_R_OUT && !rsp_err_c) ? REG_DATA_OUT : '0;
   end

   // Transaction sequencer; all strobes/responses default low each cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= ST_ARB;
         rr_ptr         <= '0;
         owner          <= '0;
         cmd_q          <= '0;
         addr_q         <= '0;
         data_q         <= '0;
         REQ_READY      <= '0;
         RSP_VALID      <= '0;
         RSP_DATA       <= '0;
         RSP_OK         <= 1'b0;
         RSP_ERR        <= 1'b0;
         BUSY           <= 1'b0;
         REG_START      <= 1'b0;
         REG_STATE_R    <= 1'b0;
         REG_STATE_W    <= 1'b0;
         REG_STATE_FAIL <= 1'b0;
         REG_ADDR       <= '0;
         REG_DATA_IN    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         to_cnt         <= '0;
`endif
      end else begin
         REQ_READY      <= '0;
         RSP_VALID      <= '0;
         RSP_DATA       <= '0;
         RSP_OK         <= 1'b0;
         RSP_ERR        <= 1'b0;
         REG_START      <= 1'b0;
         REG_STATE_R    <= 1'b0;
         REG_STATE_W    <= 1'b0;
         REG_STATE_FAIL <= 1'b0;
         REG_ADDR       <= '0;
         REG_DATA_IN    <= '0;
         case (state)
            ST_ARB: begin
               if (any_c) begin
                  REQ_READY <= grant_c;
                  owner     <= grant_c;
                  cmd_q     <= sel_cmd_c;
                  addr_q    <= sel_addr_c;
                  data_q    <= sel_data_c;
                  rr_ptr    <= ptr_next_c;
                  state     <= ST_ISSUE;
                  BUSY      <= 1'b1;
               end
            end
            ST_ISSUE: begin
               REG_START      <= 1'b1;
               REG_STATE_R    <= strb_c.state_r;
               REG_STATE_W    <= strb_c.state_w;
               REG_STATE_FAIL <= strb_c.state_fail;
               REG_ADDR       <= addr_q;
               REG_DATA_IN    <= data_q;
               state          <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
               to_cnt         <= '0;
`endif
            end
            ST_WAIT: begin
               if (REG_DONE) begin
                  RSP_VALID <= owner;
                  RSP_DATA  <= rsp_data_c;
                  RSP_OK    <= rsp_ok_c;
                  RSP_ERR   <= rsp_err_c;
                  state     <= ST_RESP;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  RSP_VALID <= owner;
                  RSP_ERR   <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
`endif
            end
            ST_RESP: begin
               state <= ST_ARB;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= ST_ARB;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Directed bench for uart_reg_arbiter (NUM_REQ=2, ADDR_W=8, DATA_W=32).
// A small register-block model answers START with DONE two cycles later.
module tb_uart_reg_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [3:0]  req_cmd;
   logic [15:0] req_addr;
   logic [63:0] req_data;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_ok;
   logic        rsp_err;
   logic        busy;
   logic        reg_start;
   logic        reg_state_r;
   logic        reg_state_w;
   logic        reg_state_fail;
   logic [7:0]  reg_addr;
   logic [31:0] reg_data_in;
   logic [31:0] reg_data_out;
   logic        reg_state_r_out;
   logic        reg_ok;
   logic        reg_fail_out;
   logic        reg_done;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   uart_reg_arbiter #(
      .NUM_REQ     (2),
      .ADDR_W      (8),
      .DATA_W      (32),
      .TIMEOUT_CYC (16)
   ) dut (
      .CLK             (clk),
      .RST             (rst),
      .REQ_VALID       (req_valid),
      .REQ_CMD         (req_cmd),
      .REQ_ADDR        (req_addr),
      .REQ_DATA        (req_data),
      .REQ_READY       (req_ready),
      .RSP_VALID       (rsp_valid),
      .RSP_DATA        (rsp_data),
      .RSP_OK          (rsp_ok),
      .RSP_ERR         (rsp_err),
      .BUSY            (busy),
      .REG_START       (reg_start),
      .REG_STATE_R     (reg_state_r),
      .REG_STATE_W     (reg_state_w),
      .REG_STATE_FAIL  (reg_state_fail),
      .REG_ADDR        (reg_addr),
      .REG_DATA_IN     (reg_data_in),
      .REG_DATA_OUT    (reg_data_out),
      .REG_STATE_R_OUT (reg_state_r_out),
      .REG_OK          (reg_ok),
      .REG_FAIL_OUT    (reg_fail_out),
      .REG_DONE        (reg_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-block model
   logic [31:0] mem [256];
   logic [2:0]  m_kind;
   logic [7:0]  m_addr;
   logic [31:0] m_data;
   int          lat = 0;
   logic        pend = 1'b0;
   logic        hold_done = 1'b0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      m_kind = '0; m_addr = '0; m_data = '0;
      reg_done = 0; reg_state_r_out = 0; reg_ok = 0; reg_fail_out = 0; reg_data_out = '0;
   end

   always @(posedge clk) begin
      #1;
      reg_done = 0; reg_state_r_out = 0; reg_ok = 0; reg_fail_out = 0; reg_data_out = '0;
      if (rst) begin
         lat  = 0;
         pend = 1'b0;
      end else begin
         if (lat != 0) begin
            lat--;
            if (lat == 0) pend = 1'b1;
         end
         if (pend && !hold_done) begin
            pend     = 1'b0;
            reg_done = 1'b1;
            if (m_kind == 3'b100) begin
               reg_state_r_out = 1'b1;
               reg_data_out    = mem[m_addr];
            end else if (m_kind == 3'b010) begin
               mem[m_addr] = m_data;
               reg_ok      = 1'b1;
            end else begin
               reg_fail_out = 1'b1;
            end
         end
         if (reg_start) begin
            m_kind = {reg_state_r, reg_state_w, reg_state_fail};
            m_addr = reg_addr;
            m_data = reg_data_in;
            lat    = 2;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_ok, rsp_err, busy,
                            reg_start, reg_state_r, reg_state_w, reg_state_fail}, '0);
      check({tag, "_bus"}, {rsp_data, reg_addr, reg_data_in}, '0);
   endtask

   // Bounded wait for a grant, then compare it with the expected one-hot
   task automatic wait_ready(input logic [1:0] exp, input string tag);
      int n;
      n = 0;
      tick();
      while (req_ready == 2'b00 && n < 20) begin
         tick();
         n++;
      end
      check(tag, req_ready, exp);
   endtask

   task automatic set_req(input int idx, input logic [1:0] cmd, input logic [7:0] addr,
                          input logic [31:0] data);
      req_cmd[idx*2 +: 2]   = cmd;
      req_addr[idx*8 +: 8]  = addr;
      req_data[idx*32 +: 32] = data;
      req_valid[idx]        = 1'b1;
   endtask

   task automatic do_txn(input int idx, input logic [1:0] cmd, input logic [7:0] addr,
                         input logic [31:0] data, input logic [2:0] exp_strb,
                         input logic [31:0] exp_rdata, input logic exp_ok, input logic exp_err,
                         input string tag);
      logic [1:0] oh;
      oh = 2'(1 << idx);
      set_req(idx, cmd, addr, data);
      wait_ready(oh, {tag, "_ready"});
      req_valid[idx] = 1'b0;
      tick();
      check({tag, "_start"}, {busy, reg_start, reg_state_r, reg_state_w, reg_state_fail},
            {2'b11, exp_strb});
      check({tag, "_regbus"}, {reg_addr, reg_data_in}, {addr, data});
      tick();
      tick();
      tick();
      check({tag, "_rsp"}, {rsp_valid, rsp_ok, rsp_err}, {oh, exp_ok, exp_err});
      check({tag, "_rdata"}, rsp_data, exp_rdata);
      tick();
      check({tag, "_idle"}, {rsp_valid, busy}, '0);
   endtask

   initial begin
      int last;
      int n;
      logic [1:0] exp_oh;
      logic saw_rsp;

      clk = 0; rst = 1;
      req_valid = '0; req_cmd = '0; req_addr = '0; req_data = '0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 0;

      // Single write, then read back from the other requester
      do_txn(0, 2'b01, 8'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b1, 1'b0, "wr0");
      do_txn(1, 2'b00, 8'h10, 32'h0, 3'b100, 32'hDEADBEEF, 1'b0, 1'b0, "rd1");

      // Contention from reset: both held valid, grants must alternate
      rst = 1;
      tick();
      tick();
      rst = 0;
      set_req(0, 2'b01, 8'h20, 32'hA0A0A0A0);
      set_req(1, 2'b01, 8'h21, 32'hB1B1B1B1);
      last = 0;
      for (int k = 0; k < 4; k++) begin
         exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
         wait_ready(exp_oh, "rr_grant");
         if (k > 0) check("rr_gap_ge5", (cyc - last) >= 5, 1'b1);
         last = cyc;
         tick();
         tick();
         tick();
         tick();
         check("rr_rsp", {rsp_valid, rsp_ok, rsp_err}, {exp_oh, 2'b10});
      end
      req_valid = '0;
      tick();
      tick();

      // Fail-report and illegal command
      do_txn(0, 2'b10, 8'h30, 32'h00001234, 3'b001, 32'h0, 1'b0, 1'b1, "fail0");
      do_txn(1, 2'b11, 8'h31, 32'h00005678, 3'b001, 32'h0, 1'b0, 1'b1, "ill1");
      do_txn(0, 2'b00, 8'h20, 32'h0, 3'b100, 32'hA0A0A0A0, 1'b0, 1'b0, "rd_rr0");

      // Reset one cycle after START; req0 aborted, so pointer would favour req1 without reset
      set_req(0, 2'b01, 8'h40, 32'h11111111);
      wait_ready(2'b01, "abort_ready");
      req_valid = '0;
      tick();
      check("abort_start", reg_start, 1'b1);
      rst = 1;
      tick();
      check_all_zero("abort_reset");
      #1 rst = 0;
      saw_rsp = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (rsp_valid != 2'b00) saw_rsp = 1'b1;
      end
      check("abort_no_rsp", saw_rsp, 1'b0);
      set_req(0, 2'b00, 8'h10, 32'h0);
      set_req(1, 2'b00, 8'h40, 32'h0);
      wait_ready(2'b01, "abort_next_grant");
      req_valid = '0;
      tick();
      tick();
      tick();
      tick();
      check("abort_next_rsp", {rsp_valid, rsp_data}, {2'b01, 32'hDEADBEEF});
      tick();
      tick();

      // Register never answers
      hold_done = 1'b1;
      set_req(1, 2'b00, 8'h10, 32'h0);
      wait_ready(2'b10, "hold_ready");
      req_valid = '0;
`ifdef UART_ARB_TIMEOUT_EN
      n = 0;
      while (rsp_valid == 2'b00 && n < 40) begin
         tick();
         n++;
      end
      check("to_latency", n, 17);
      check("to_rsp", {rsp_valid, rsp_ok, rsp_err, rsp_data}, {2'b10, 1'b0, 1'b1, 32'h0});
      tick();
      check("to_busy_drop", busy, 1'b0);
      hold_done = 1'b0;
      saw_rsp = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (rsp_valid != 2'b00) saw_rsp = 1'b1;
      end
      check("to_late_done_ignored", {saw_rsp, busy}, '0);
`else
      saw_rsp = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (rsp_valid != 2'b00) saw_rsp = 1'b1;
      end
      check("hold_no_rsp", {saw_rsp, busy}, 2'b01);
      hold_done = 1'b0;
      n = 0;
      while (rsp_valid == 2'b00 && n < 6) begin
         tick();
         n++;
      end
      check("hold_rsp", {rsp_valid, rsp_ok, rsp_err, rsp_data}, {2'b10, 2'b00, 32'hDEADBEEF});
      tick();
      check("hold_busy_drop", busy, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
